fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of Control_Unit in the 16-bit multi-register accumulator processor.
- Holds the PC and the instruction register (IR), and runs a req/ready read handshake to instruction memory.
- Presents decoded Opcode/Func/immediate fields that Control_Unit consumes.
- Control_Unit starts fetches via fetch_req and redirects the PC on jumps via jump_en/jump_target.

---
 rtl/fetch_unit_pkg.sv | 33 +++
 rtl/fetch_timeout_ctr.sv | 38 +++
 rtl/fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the 16-bit accumulator processor front end.
//   Contents: FSM state encodings and the state enum, instruction field bit
//   positions, and the default reset PC.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

   // Raw state encodings, also used for the enum so that debug dumps and
   // state_dbg values are stable across revisions.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_FETCH = ST_FETCH,
      S_DONE  = ST_DONE
   } state_t;

   // Instruction field positions (16-bit instruction word).
   localparam int OPC_HI  = 15;
   localparam int OPC_LO  = 12;
   localparam int RSEL_HI = 11;
   localparam int RSEL_LO = 8;
   localparam int FUNC_HI = 3;
   localparam int FUNC_LO = 0;
   localparam int IMM_HI  = 11;
   localparam int IMM_LO  = 0;

   localparam logic [15:0] RESET_PC_DEF = 16'h0000;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// ---------------------------------------------------------------------------
// fetch_timeout_ctr
//   Wait-cycle counter for an outstanding instruction fetch.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : synchronous clear (start of a new fetch)
//     en         : count one cycle without mem_ready
//     last       : high when one more counted cycle reaches LIMIT, i.e. the
//                  current cycle is the final one allowed; never high when
//                  LIMIT is 0 (timeout disabled)
// ---------------------------------------------------------------------------
module fetch_timeout_ctr #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CW'(1);
      end
   end

   assign last = (LIMIT != 0) && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage: owns the PC and IR, runs a req/ready read to
//   instruction memory and presents decoded fields to Control_Unit.
//
//   Handshake: mem_req and mem_addr are held stable from the first FETCH cycle
//   until a cycle in which mem_ready is sampled high at the rising edge; that
//   edge completes the transfer. mem_ready/mem_rdata are ignored outside FETCH.
//
//   Ports:
//     CLK, Reset            : clock, asynchronous active-low reset
//     fetch_req             : start a fetch at the current PC (IDLE/DONE)
//     jump_en, jump_target  : PC redirect
//     mem_req, mem_addr     : read request / address to instruction memory
//     mem_ready, mem_rdata  : memory response
//     Opcode, Rsel, Func,
//     Imm12                 : combinational slices of IR
//     pc_out                : current PC
//     fetch_done            : one-cycle pulse after IR is updated
//     instr_valid           : IR holds a fetched, non-discarded instruction
//     fetch_err             : sticky timeout flag, cleared by the next fetch
//     busy                  : FSM is in FETCH
//     state_dbg             : raw FSM state for observation
// ---------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
   parameter int                PC_INC   = 2,
   parameter int                TIMEOUT  = 15
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              fetch_req,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_target,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [3:0]        Opcode,
   output logic [3:0]        Func,
   output logic [3:0]        Rsel,
   output logic [11:0]       Imm12,
   output logic [ADDR_W-1:0] pc_out,
   output logic              fetch_done,
   output logic              instr_valid,
   output logic              fetch_err,
   output logic              busy,
   output logic [1:0]        state_dbg
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic              pend;
   logic [ADDR_W-1:0] pend_tgt;

   // FSM decisions for the current cycle.
   logic start;       // fetch accepted from IDLE/DONE
   logic take_word;   // transfer completes, word kept
   logic discard;     // transfer completes, word dropped due to a jump
   logic timeout;     // wait budget exhausted
   logic cnt_en;
   logic ctr_last;

   // A jump seen in the same cycle as completion/timeout is the most recent
   // one, so it takes priority over a previously latched target.
   logic              have_jump;
   logic [ADDR_W-1:0] redirect;

   assign have_jump = jump_en | pend;
   assign redirect  = jump_en ? jump_target : pend_tgt;

   fetch_timeout_ctr #(
      .LIMIT (TIMEOUT)
   ) u_timeout_ctr (
      .clk   (CLK),
      .rst_n (Reset),
      .clr   (start),
      .en    (cnt_en),
      .last  (ctr_last)
   );

   // State register.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-cycle decisions.
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      start     = 1'b0;
      take_word = 1'b0;
      discard   = 1'b0;
      timeout   = 1'b0;
      cnt_en    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (fetch_req) begin
               state_nxt = S_FETCH;
               start     = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               if (have_jump) begin
                  discard   = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  take_word = 1'b1;
                  state_nxt = S_DONE;
               end
            end else if (ctr_last) begin
               timeout   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // PC, IR, pending-jump and status registers.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         pc          <= RESET_PC;
         ir          <= '0;
         pend        <= 1'b0;
         pend_tgt    <= '0;
         instr_valid <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         // Outside FETCH a jump moves the PC immediately, so a fetch accepted
         // on the same edge is issued at the new target.
         if (state != S_FETCH && jump_en) begin
            pc <= jump_target;
         end
         if (start) begin
            fetch_err <= 1'b0;
         end
         // Inside FETCH the address must stay stable; remember the jump.
         if (state == S_FETCH && jump_en) begin
            pend     <= 1'b1;
            pend_tgt <= jump_target;
         end
         if (take_word) begin
            ir          <= mem_rdata;
            pc          <= pc + ADDR_W'(PC_INC);
            instr_valid <= 1'b1;
         end
         if (discard) begin
            pc          <= redirect;
            pend        <= 1'b0;
            instr_valid <= 1'b0;
         end
         if (timeout) begin
            fetch_err   <= 1'b1;
            instr_valid <= 1'b0;
            pend        <= 1'b0;
            if (have_jump) begin
               pc <= redirect;
            end
         end
      end
   end

   assign mem_addr   = pc;
   assign pc_out     = pc;
   assign Opcode     = ir[OPC_HI:OPC_LO];
   assign Rsel       = ir[RSEL_HI:RSEL_LO];
   assign Func       = ir[FUNC_HI:FUNC_LO];
   assign Imm12      = ir[IMM_HI:IMM_LO];
   assign fetch_done = (state == S_DONE);
   assign busy       = (state == S_FETCH);
   assign state_dbg  = state;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        Reset;
  logic        fetch_req;
  logic        jump_en;
  logic [15:0] jump_target;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [3:0]  Opcode;
  logic [3:0]  Func;
  logic [3:0]  Rsel;
  logic [11:0] Imm12;
  logic [15:0] pc_out;
  logic        fetch_done;
  logic        instr_valid;
  logic        fetch_err;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Expected {IR, PC-after-fetch} for every fetch_done pulse.
  logic [31:0] exp_q[$];

  fetch_unit dut (
    .CLK         (clk),
    .Reset       (Reset),
    .fetch_req   (fetch_req),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .Opcode      (Opcode),
    .Func        (Func),
    .Rsel        (Rsel),
    .Imm12       (Imm12),
    .pc_out      (pc_out),
    .fetch_done  (fetch_done),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (Reset === 1'b1 && fetch_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_fetch_done act=%h exp=none", pc_out);
      end else begin
        logic [31:0] e;
        logic [31:0] a;
        e = exp_q.pop_front();
        a = {Opcode, Rsel, Imm12[7:4], Func, pc_out};
        if (a !== e || instr_valid !== 1'b1) begin
          errors++;
          $display("FAIL fetch_result act=%h valid=%b exp=%h valid=1", a, instr_valid, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    Reset = 1'b1;
    fetch_req = 1'b0;
    jump_en = 1'b0;
    jump_target = 16'h0000;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    #2 Reset = 1'b0;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_pc", {16'd0, pc_out}, 32'h0000);
    chk("rst_ir", {16'd0, Opcode, Imm12}, 32'h0000);
    chk("rst_flags", {28'd0, fetch_done, instr_valid, fetch_err, busy}, 32'd0);
    tick();
    tick();
    Reset = 1'b1;

    // 1: zero-wait fetch of 16'h2A35 at 0x0000
    fetch_req = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 16'h2A35;
    tick();
    fetch_req = 1'b0;
    chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1_mem_addr", {16'd0, mem_addr}, 32'h0000);
    exp_q.push_back({16'h2A35, 16'h0002});
    tick();
    chk("t1_fields", {20'd0, Opcode, Rsel, Func}, 32'h2A5);
    chk("t1_imm12", {20'd0, Imm12}, 32'hA35);
    chk("t1_fetch_done", {31'd0, fetch_done}, 32'd1);
    mem_ready = 1'b0;
    tick();
    chk("t1_done_pulse", {31'd0, fetch_done}, 32'd0);

    // 2: three wait states
    fetch_req = 1'b1;
    mem_rdata = 16'hC3F1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ready = 1'b1;
        exp_q.push_back({16'hC3F1, 16'h0004});
      end
      chk("t2_mem_req", {31'd0, mem_req}, 32'd1);
      chk("t2_mem_addr", {16'd0, mem_addr}, 32'h0002);
      tick();
    end
    chk("t2_fetch_err", {31'd0, fetch_err}, 32'd0);
    mem_ready = 1'b0;
    tick();

    // 3: jump plus fetch together in IDLE
    jump_en = 1'b1;
    jump_target = 16'h0100;
    fetch_req = 1'b1;
    tick();
    jump_en = 1'b0;
    fetch_req = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'h7B08;
    chk("t3_mem_addr", {16'd0, mem_addr}, 32'h0100);
    exp_q.push_back({16'h7B08, 16'h0102});
    tick();
    mem_ready = 1'b0;
    tick();
    chk("t3_pc", {16'd0, pc_out}, 32'h0102);

    // 4: jump during FETCH with two wait states -> word discarded
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    jump_en = 1'b1;
    jump_target = 16'h0040;
    mem_rdata = 16'hFFFF;
    chk("t4_addr_c1", {16'd0, mem_addr}, 32'h0102);
    tick();
    jump_en = 1'b0;
    chk("t4_addr_c2", {16'd0, mem_addr}, 32'h0102);
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("t4_state", {30'd0, state_dbg}, 32'd0);
    chk("t4_valid", {31'd0, instr_valid}, 32'd0);
    chk("t4_pc", {16'd0, pc_out}, 32'h0040);
    chk("t4_ir_kept", {16'd0, Opcode, Imm12}, 32'h7B08);

    // 4b: jump coincident with mem_ready -> still discarded
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'h5555;
    jump_en = 1'b1;
    jump_target = 16'h0200;
    chk("t4b_mem_addr", {16'd0, mem_addr}, 32'h0040);
    tick();
    mem_ready = 1'b0;
    jump_en = 1'b0;
    chk("t4b_pc", {16'd0, pc_out}, 32'h0200);
    chk("t4b_ir_kept", {16'd0, Opcode, Imm12}, 32'h7B08);
    chk("t4b_state", {30'd0, state_dbg}, 32'd0);

    // 5: timeout with mem_ready held low
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      n++;
      tick();
    end
    chk("t5_req_cycles", n, 32'd15);
    chk("t5_fetch_err", {31'd0, fetch_err}, 32'd1);
    chk("t5_pc", {16'd0, pc_out}, 32'h0200);
    chk("t5_busy_valid", {30'd0, busy, instr_valid}, 32'd0);
    tick();
    tick();
    chk("t5_err_sticky", {31'd0, fetch_err}, 32'd1);
    fetch_req = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 16'h1234;
    tick();
    fetch_req = 1'b0;
    chk("t5_err_cleared", {31'd0, fetch_err}, 32'd0);
    exp_q.push_back({16'h1234, 16'h0202});
    tick();
    mem_ready = 1'b0;
    tick();

    // 6: PC wrap from 0xFFFE
    jump_en = 1'b1;
    jump_target = 16'hFFFE;
    fetch_req = 1'b1;
    tick();
    jump_en = 1'b0;
    fetch_req = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'h9E0C;
    chk("t6_mem_addr", {16'd0, mem_addr}, 32'hFFFE);
    exp_q.push_back({16'h9E0C, 16'h0000});
    tick();
    mem_ready = 1'b0;
    tick();
    chk("t6_pc_wrap", {16'd0, pc_out}, 32'h0000);

    // 7: reset asserted mid-FETCH
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("t7_mem_req_pre", {31'd0, mem_req}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("t7_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t7_pc", {16'd0, pc_out}, 32'h0000);
    chk("t7_ir", {16'd0, Opcode, Imm12}, 32'h0000);
    chk("t7_flags", {29'd0, instr_valid, busy, fetch_done}, 32'd0);
    tick();
    Reset = 1'b1;
    tick();
    tick();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
